// File: rtl/uart_frame_tx.sv
// Serial frame transmitter: buffers words in a small FIFO and sends each one as
// start bit, data LSB-first, parity bit, stop bit, at one bit per clock.
module uart_frame_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  out,
    output logic                  busy,
    output logic                  done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_en_q;
    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign fifo_empty = (count_q == '0);
    assign fifo_head  = mem_q[rd_ptr_q];
    // ready_en_q holds s_ready low through reset and opens it on the first edge after release.
    assign s_ready    = ready_en_q && (count_q != FULL_COUNT);
    assign push       = s_valid && s_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; count and pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  out_q, out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Line outputs are computed from the current state and registered, so they trail the state by one cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        pop       = 1'b0;
        out_d     = 1'b1;
        busy_d    = 1'b1;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                out_d     = 1'b0;
                bit_cnt_d = '0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                out_d     = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                out_d   = par_q;
                state_d = S_STOP;
            end
            S_STOP: begin
                done_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            shift_d = fifo_head;
            par_d   = (^fifo_head) ^ PARITY_ODD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            out_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: even/odd-parity instances, table-driven
// single frames plus hand-written back-to-back, backpressure, loopback and reset cases.
module tb_uart_frame_tx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          arst_n;
    logic [DW-1:0] s_data;
    logic          s_valid_e, s_valid_o;
    logic          s_ready_e, out_e, busy_e, done_e;
    logic          s_ready_o, out_o, busy_o, done_o;

    always #5 clk = ~clk;

    uart_frame_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid_e), .s_data(s_data),
        .s_ready(s_ready_e), .out(out_e), .busy(busy_e), .done(done_e)
    );

    uart_frame_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .arst_n(arst_n), .s_valid(s_valid_o), .s_data(s_data),
        .s_ready(s_ready_o), .out(out_o), .busy(busy_o), .done(done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame decoder on the even-parity line: records {stop, done, parity, data}.
    logic [10:0] frame_q[$];
    int          mon_pos = 0;
    logic [7:0]  mon_data;
    logic        mon_par;

    always @(negedge clk) begin
        if (!arst_n) begin
            mon_pos = 0;
        end else if (mon_pos == 0) begin
            if (busy_e && !out_e) mon_pos = 1;
        end else if (mon_pos <= DW) begin
            mon_data[mon_pos-1] = out_e;
            mon_pos++;
        end else if (mon_pos == DW + 1) begin
            mon_par = out_e;
            mon_pos++;
        end else begin
            frame_q.push_back({out_e, done_e, mon_par, mon_data});
            mon_pos = 0;
        end
    end

    typedef struct {
        logic          odd;
        logic [DW-1:0] data;
        logic          exp_par;
    } vec_t;

    vec_t vecs[8];

    // Called at a negedge with the selected instance idle.
    task automatic run_vec(input vec_t v, input int idx);
        logic [10:0] exp_line;
        logic [2:0]  got;
        logic [2:0]  exp;
        exp_line = {1'b1, v.exp_par, v.data, 1'b0};
        check($sformatf("vec%0d ready", idx), v.odd ? s_ready_o : s_ready_e, 1);
        s_data = v.data;
        if (v.odd) s_valid_o = 1'b1; else s_valid_e = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_valid_e = 1'b0;
        s_valid_o = 1'b0;
        @(negedge clk);
        got = v.odd ? {out_o, busy_o, done_o} : {out_e, busy_e, done_e};
        check($sformatf("vec%0d pre-start out/busy/done", idx), got, 3'b100);
        for (int b = 0; b < 12; b++) begin
            @(negedge clk);
            got = v.odd ? {out_o, busy_o, done_o} : {out_e, busy_e, done_e};
            if (b < 11) exp = {exp_line[b], 1'b1, (b == 10)};
            else        exp = 3'b100;
            check($sformatf("vec%0d bit%0d out/busy/done", idx, b), got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_e(input logic [DW-1:0] w, output int waited);
        waited    = 0;
        s_data    = w;
        s_valid_e = 1'b1;
        while (!s_ready_e && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("push timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        s_valid_e = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (frame_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({name, " frame count"}, frame_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] bp_w[6];
        logic [DW-1:0] exp_w[$];
        logic [21:0]   stream;
        logic [DW-1:0] w;
        int            acc[6];
        int            waited;
        int            bad;

        vecs[0] = '{1'b0, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 8'hFF, 1'b0};
        vecs[3] = '{1'b0, 8'h01, 1'b1};
        vecs[4] = '{1'b0, 8'h80, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 8'h01, 1'b0};
        vecs[7] = '{1'b1, 8'h3C, 1'b1};

        arst_n    = 1'b0;
        s_valid_e = 1'b0;
        s_valid_o = 1'b0;
        s_data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset even out/busy/done/ready", {out_e, busy_e, done_e, s_ready_e}, 4'b1000);
        check("reset odd out/busy/done/ready",  {out_o, busy_o, done_o, s_ready_o}, 4'b1000);
        arst_n = 1'b1;
        @(negedge clk);
        check("post-reset even ready/out/busy", {s_ready_e, out_e, busy_e}, 3'b110);
        check("post-reset odd ready/out/busy",  {s_ready_o, out_o, busy_o}, 3'b110);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Back-to-back 0x00 then 0xFF: 22 contiguous bits, done at bits 10 and 21.
        stream = {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        s_data    = 8'h00;
        s_valid_e = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_data = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        s_valid_e = 1'b0;
        for (int b = 0; b < 22; b++) begin
            @(negedge clk);
            check($sformatf("b2b bit%0d out/busy/done", b), {out_e, busy_e, done_e},
                  {stream[b], 1'b1, (b == 10 || b == 21)});
        end
        @(negedge clk);
        check("b2b idle out/busy/done", {out_e, busy_e, done_e}, 3'b100);

        // Backpressure: six words held back to back into a 4-deep FIFO.
        frame_q.delete();
        bp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int k = 0; k < 6; k++) begin
            if (k == 5) check("bp ready low with 4 buffered", s_ready_e, 0);
            push_e(bp_w[k], waited);
            acc[k] = cyc;
        end
        for (int k = 1; k < 5; k++) check($sformatf("bp accept offset w%0d", k), acc[k] - acc[0], k);
        check("bp accept offset w5", acc[5] - acc[0], 13);
        wait_frames(6, 200, "bp");
        for (int k = 0; k < 6 && k < frame_q.size(); k++)
            check($sformatf("bp frame%0d", k), frame_q[k], {1'b1, 1'b1, ^bp_w[k], bp_w[k]});
        repeat (3) @(negedge clk);

        // Loopback-style decode of a 50-word stream.
        frame_q.delete();
        for (int i = 0; i < 50; i++) begin
            w = 8'($urandom);
            exp_w.push_back(w);
            push_e(w, waited);
        end
        wait_frames(50, 1000, "loopback");
        for (int i = 0; i < 50 && i < frame_q.size(); i++)
            check($sformatf("loopback frame%0d", i), frame_q[i], {1'b1, 1'b1, ^exp_w[i], exp_w[i]});
        repeat (3) @(negedge clk);

        // Reset in the middle of 0x3C with two words buffered.
        frame_q.delete();
        push_e(8'h3C, waited);
        push_e(8'h5A, waited);
        push_e(8'h96, waited);
        repeat (2) @(negedge clk);
        check("mid-frame busy before reset", busy_e, 1);
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid-frame reset out/busy/done/ready", {out_e, busy_e, done_e, s_ready_e}, 4'b1000);
        arst_n = 1'b1;
        @(negedge clk);
        check("after reset ready", s_ready_e, 1);
        bad = 0;
        for (int t = 0; t < 30; t++) begin
            if (out_e !== 1'b1 || busy_e !== 1'b0 || done_e !== 1'b0) bad++;
            @(negedge clk);
        end
        check("after reset line quiet cycles", bad, 0);
        check("after reset frames seen", frame_q.size(), 0);
        push_e(8'h77, waited);
        wait_frames(1, 50, "after reset");
        if (frame_q.size() > 0) check("after reset frame", frame_q[0], {1'b1, 1'b1, ^8'h77, 8'h77});
        repeat (15) @(negedge clk);
        check("after reset no extra frames", frame_q.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Serial frame transmitter: the stage directly upstream of `receiver`.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word at one bit per `clk` as: start bit, data LSB-first, parity bit, stop bit.
- Drives the line sampled by `receiver`'s `in`; a looped-back frame appears on `receiver`'s 9-bit `out` as {parity, data}.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `FIFO_DEPTH`, 4: input buffer depth in words; power of 2, ≥ 2.
- `PARITY_ODD`, 0: 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (inverted XOR).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `arst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  input word valid.
- `s_data`  in  DATA_WIDTH  input word.
- `s_ready`  out  1  input can accept a word.
- `out`  out  1  serial line, registered; idles high.
- `busy`  out  1  high while a frame is on the line, START through STOP.
- `done`  out  1  one-cycle pulse, high during the STOP bit cycle.

## Operation
- Push: a word is written to the FIFO on any edge where `s_valid && s_ready`.
- `s_ready` = !full. It depends only on the registered FIFO count.
  - When the FIFO is full, a pop in the same cycle does not raise `s_ready` until the next cycle.
- FIFO uses wrapping read/write pointers plus a count of width clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `out`=1. If the FIFO is non-empty, pop the head into the shift register, latch the parity of the word, go to START.
  - START: `out`=0, bit counter cleared, go to DATA.
  - DATA: `out`=shift[0], shift right each cycle. After DATA_WIDTH cycles, go to PARITY.
  - PARITY: `out`=parity bit, go to STOP.
  - STOP: `out`=1, `done`=1.
    - If the FIFO is non-empty, pop the head and go directly to START, with no idle bit between frames.
    - Otherwise go to IDLE.
- Frame length: DATA_WIDTH+3 cycles (11 for the defaults).
- Bit counter width: clog2(DATA_WIDTH)+1. It must not wrap before DATA_WIDTH.
- Reset while `arst_n`=0, applied at the edge:
  - Outputs: `out`=1, `busy`=0, `done`=0, `s_ready`=0.
  - State: FSM=IDLE, FIFO emptied, pointers and count cleared.
  - `s_ready`=1 from the first edge after `arst_n` returns high.
- Reset mid-frame: the current frame is truncated. The line returns to 1 at the reset edge, and all buffered words are discarded, with no `done` pulse.
- `s_data` is don't-care when `s_valid`=0. Words are never dropped or duplicated.

## Timing
- Word accepted at edge N with the FIFO empty and FSM in IDLE:
  - start bit on `out` after edge N+2;
  - data bit i after edge N+3+i;
  - parity after edge N+3+DATA_WIDTH;
  - stop after edge N+4+DATA_WIDTH.
  - `done` high for the stop cycle only.
- Back-to-back frames: the next start bit follows the stop bit immediately, so the line carries a continuous bit stream.
- `busy` is registered with the state. It is low only in IDLE.
- FIFO pop happens on the IDLE→START or STOP→START edge. A slot freed by that pop is visible on `s_ready` in the following cycle.

## Test plan
- Single word, defaults: push 0xA5 → `out` = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, even parity 0, stop) → `done` pulses once, then `out` stays 1 and `busy`=0.
- Back-to-back: push 0x00, then 0xFF → 22 contiguous bits 0,00000000,0,1,0,11111111,0,1 → no idle bit between frames → two `done` pulses 11 cycles apart.
- Odd parity (`PARITY_ODD`=1): push 0x00 → parity bit 1; push 0x01 → parity bit 0.
- Backpressure, `FIFO_DEPTH`=4: hold `s_valid` with 6 distinct words.
  - Words 0–4 are accepted; the first is popped immediately.
  - `s_ready` falls once 4 words are buffered, and word 5 stalls until the end of frame 0.
  - All 6 frames are sent in order, none lost.
- Loopback into `receiver` (`DATA_WIDTH`=8): random 50-word stream → each `receiver` `done` shows `out` = {expected parity, word}.
- Reset mid-frame: assert `arst_n`=0 during DATA of 0x3C with 2 words buffered.
  - `out`=1, `busy`=0 at the reset edge.
  - After release, the FIFO is empty and nothing more is transmitted until a new push.
